// File: rtl/v_update_issue.sv
// Ingress FIFO feeding the no-backpressure update bus of v_update_pipe.
// Holds the head back while its prod_id is still in flight, so the downstream state RMW sees no RAW hazard.
package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [1:0]  cmd_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] size_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;
endpackage

module v_update_issue #(
    parameter int DEPTH         = 4,
    parameter int HAZARD_WINDOW = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_vld,
    output logic                   o_in_rdy,
    input  v_pkg::id_t             i_in_prod_id,
    input  v_pkg::cmd_t            i_in_cmd,
    input  v_pkg::key_t            i_in_key,
    input  v_pkg::size_t           i_in_size,
    output logic                   o_upd_vld_r,
    output v_pkg::id_t             o_upd_prod_id_r,
    output v_pkg::cmd_t            o_upd_cmd_r,
    output v_pkg::key_t            o_upd_key_r,
    output v_pkg::size_t           o_upd_size_r,
    output logic [$clog2(DEPTH):0] o_level_r,
    output logic [15:0]            o_stall_cnt_r
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    v_pkg::upd_t mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic [15:0] stall_q, stall_d;
    v_pkg::upd_t upd_q, upd_d;
    logic        upd_vld_q, upd_vld_d;

    logic [HAZARD_WINDOW-1:0]             hist_vld_q, hist_vld_d;
    v_pkg::id_t [HAZARD_WINDOW-1:0]       hist_id_q, hist_id_d;
    logic [HAZARD_WINDOW-1:0]             hit;

    v_pkg::upd_t head;
    logic        empty, full, push, pop, blocked;

    // Extra pointer MSB separates a wrapped-full FIFO from an empty one.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_in_rdy = !full && !rst;
    assign push     = i_in_vld && o_in_rdy;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    generate
        for (genvar gi = 0; gi < HAZARD_WINDOW; gi++) begin : g_hist
            assign hit[gi] = hist_vld_q[gi] && (hist_id_q[gi] == head.prod_id);
            if (gi == 0) begin : g_head
                assign hist_vld_d[gi] = pop;
                assign hist_id_d[gi]  = head.prod_id;
            end else begin : g_shift
                assign hist_vld_d[gi] = hist_vld_q[gi-1];
                assign hist_id_d[gi]  = hist_id_q[gi-1];
            end
        end
    endgenerate

    assign blocked = |hit;
    assign pop     = !empty && !blocked;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        stall_d   = stall_q;
        upd_d     = upd_q;
        upd_vld_d = pop;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            upd_d    = head;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
        if (!empty && blocked && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{i_in_prod_id, i_in_cmd, i_in_key, i_in_size};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            stall_q    <= '0;
            upd_q      <= '0;
            upd_vld_q  <= 1'b0;
            hist_vld_q <= '0;
            hist_id_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            stall_q    <= stall_d;
            upd_q      <= upd_d;
            upd_vld_q  <= upd_vld_d;
            hist_vld_q <= hist_vld_d;
            hist_id_q  <= hist_id_d;
        end
    end

    assign o_upd_vld_r     = upd_vld_q;
    assign o_upd_prod_id_r = upd_q.prod_id;
    assign o_upd_cmd_r     = upd_q.cmd;
    assign o_upd_key_r     = upd_q.key;
    assign o_upd_size_r    = upd_q.size;
    assign o_level_r       = level_q;
    assign o_stall_cnt_r   = stall_q;
endmodule
